data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//   Two-port arbiter and sequencer in front of the single-port, synchronous data memory.
//   Port 0 is the CPU load/store unit; port 1 is the program/data loader (testbench or DMA).
//   It serialises requests, converts byte addresses to word addresses and checks alignment/range.
//   It sequences the memory's 1-cycle registered read, returning read data with a valid pulse.
// PARAMETERS
//   DATA_W      32   data width of both ports and of the memory
//   ADDR_W      10   memory word-address width (1024 words)
//   FIXED_PRIO  0    0 = round-robin between ports; 1 = port 0 always wins on conflict
// PORTS
//   Clock         in   1       rising-edge clock
//   Reset_n       in   1       asynchronous, active-low reset
//   p0_req        in   1       port 0 request; held high until p0_gnt
//   p0_we         in   1       port 0: 1 = write, 0 = read
//   p0_addr       in   32      port 0 byte address
//   p0_wdata      in   DATA_W  port 0 write data
//   p0_gnt        out  1       port 0 grant pulse (request accepted)
//   p0_rvalid     out  1       port 0 read-data valid pulse
//   p0_err        out  1       port 0 error pulse (misaligned/out of range)
//   p1_*          ...          identical set for port 1
//   rdata         out  DATA_W  read data, shared by both ports, qualified by px_rvalid
//   mem_addr      out  ADDR_W  word address to memory
//   mem_wdata     out  DATA_W  write data to memory
//   mem_we        out  1       memory write enable
//   mem_re        out  1       memory read enable
//   mem_rdata     in   DATA_W  memory read data, valid the cycle after mem_re
// BEHAVIOUR
//   Reset (async, Reset_n=0): state IDLE; every output 0; rdata 0; RR pointer favours port 0.
//   FSM: IDLE -> ISSUE -> (read) WAIT_RD -> IDLE | (write/err) -> IDLE.
//   IDLE: if any px_req, choose winner and latch we/addr/wdata internally; go ISSUE.
//     No request: stay IDLE, all memory controls 0.
//   Arbitration: single request wins. Both requesting: FIXED_PRIO=1 -> port 0.
//     FIXED_PRIO=0 -> port not granted last, and the pointer updates on every grant.
//   ISSUE (1 cycle): px_gnt=1 for the winner. Requester may change inputs from the next cycle.
//     Address check: addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 -> error.
//       On error: no mem_we/mem_re; px_err=1 in this same cycle; next state IDLE.
//     Otherwise mem_addr = addr[ADDR_W+1:2].
//       Write: mem_we=1 and mem_wdata driven; next state IDLE.
//       Read: mem_re=1; next state WAIT_RD.
//   WAIT_RD: capture mem_rdata into rdata at the clock edge that exits WAIT_RD.
//     px_rvalid=1 for the winner in the following cycle (state IDLE).
//   rdata holds its value until the next read completes; it is not changed by writes or errors.
//   Latency, with the request seen in IDLE at cycle N:
//     gnt at N+1; write hits memory at the end of N+1; rvalid plus data at N+3.
//   Throughput: a new arbitration happens in the same IDLE cycle that carries rvalid.
//     Back-to-back writes: 1 per 2 cycles. Back-to-back reads: 1 per 3 cycles.
//   At most one memory control is asserted per cycle; mem_we and mem_re are never both 1.
//   Request sampling: px_req is sampled only in IDLE. Dropping req before gnt is a protocol
//     violation; behaviour is undefined except that no memory write may occur for it.
//   Reset mid-operation: an in-flight write either completed at a prior edge or never occurs.
//     An in-flight read is dropped: no rvalid, and rdata is cleared to 0.
// TESTING
//   Single write then read, p0: write 0x0000_0010 <- 0xDEADBEEF.
//     -> mem_we with mem_addr=4 at N+1; read same address -> p0_rvalid at N+3, rdata=0xDEADBEEF.
//   Simultaneous p0 and p1 reads, FIXED_PRIO=0, repeated 4 times:
//     -> grants alternate p0,p1,p0,p1...; each rvalid goes to the correct port.
//   Same contention with FIXED_PRIO=1 -> p0 granted every time; p1 served only when p0_req=0.
//   Error cases: p1 addr 0x0000_0002 -> p1_gnt and p1_err in the same cycle, no mem_we/mem_re.
//     p1 addr 0x0000_1000 (word 1024) -> same response; rdata unchanged.
//   Boundary: write 0xA5A5A5A5 to addr 0x0000_0FFC -> mem_addr=1023.
//     Read back -> 0xA5A5A5A5.
//   Reset: pull Reset_n low during WAIT_RD -> all outputs 0 immediately, no rvalid.
//     After release, the first request is served normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   This module arbitrates between two requesters for a single-port synchronous data
//   memory. Port 0 is the CPU load/store unit and port 1 is the loader.
//   It turns byte addresses into word addresses and rejects misaligned or
//   out-of-range addresses. Read data returns one registered cycle after the memory
//   read, together with a valid pulse for the port that issued the read.
// Ports
//   Clock, Reset_n         rising-edge clock, asynchronous active-low reset
//   pX_req/we/addr/wdata   request from port X (byte address, held until pX_gnt)
//   pX_gnt/rvalid/err      grant, read-data-valid and error pulses to port X
//   rdata                  shared read data, qualified by pX_rvalid
//   mem_addr/wdata/we/re   word-addressed memory controls
//   mem_rdata              memory read data, valid the cycle after mem_re
module data_mem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic              p1_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t            state;
  logic              last_p1;   // 1 when port 1 received the most recent grant
  logic              sel_p1;    // owner of the transaction in flight
  logic              issue_rd;  // ISSUE cycle carries a valid read

  logic              pick_p1;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_bad;

  always_comb begin
    if (p0_req && p1_req) begin
      pick_p1 = FIXED_PRIO ? 1'b0 : ~last_p1;
    end else begin
      pick_p1 = p1_req;
    end
    req_we    = pick_p1 ? p1_we    : p0_we;
    req_addr  = pick_p1 ? p1_addr  : p0_addr;
    req_wdata = pick_p1 ? p1_wdata : p0_wdata;
    req_bad   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
  end

  // Everything shown during ISSUE is decided at the IDLE edge, so that the grant,
  // the error and the memory controls all come from registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      last_p1   <= 1'b1;
      sel_p1    <= 1'b0;
      issue_rd  <= 1'b0;
      p0_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_gnt    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      p0_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_gnt    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            state    <= ISSUE;
            sel_p1   <= pick_p1;
            last_p1  <= pick_p1;
            p0_gnt   <= ~pick_p1;
            p1_gnt   <= pick_p1;
            issue_rd <= ~req_bad & ~req_we;
            if (req_bad) begin
              p0_err <= ~pick_p1;
              p1_err <= pick_p1;
            end else begin
              mem_addr <= req_addr[ADDR_W+1:2];
              if (req_we) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                mem_re <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          state <= issue_rd ? WAIT_RD : IDLE;
        end
        WAIT_RD: begin
          rdata     <= mem_rdata;
          p0_rvalid <= ~sel_p1;
          p1_rvalid <= sel_p1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
